// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit with HI/LO result registers.
// mult/multu/div/divu hold busy for a fixed number of cycles and then write
// the result computed from the operands captured at the start edge.
// mthi/mtlo write HI/LO directly while the unit is idle. Any request made
// while busy is ignored.
module muldiv_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic        md_stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state, state_next;
  op_t           op_in;
  op_t           op_q;
  logic [31:0]   a_q, b_q;
  logic [CW-1:0] cnt;

  logic          is_md_op;
  logic          accept;
  logic          finish;

  // Result datapath signals, all derived from the captured operands.
  logic          signed_mul;
  logic          signed_div;
  logic          is_div_q;
  logic [63:0]   ext_a, ext_b, product;
  logic [31:0]   mag_a, mag_b, div_b;
  logic [31:0]   uquot, urem;
  logic [31:0]   quot, rem;
  logic [31:0]   res_hi, res_lo;
  logic          res_write;

  assign op_in    = op_t'(op);
  assign is_md_op = (op_in == OP_MULT) || (op_in == OP_MULTU) ||
                    (op_in == OP_DIV)  || (op_in == OP_DIVU);

  // The hazard unit needs the stall in the same cycle as the request.
  assign md_stall = busy | (start & is_md_op);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic with accept/finish strobes for the datapath.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    finish     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start && is_md_op) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        // cnt==1 means this edge takes it to zero; cnt==0 is only a safety net.
        if (cnt <= CW'(1)) begin
          finish     = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture and cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= OP_NONE;
      cnt  <= '0;
      busy <= 1'b0;
    end else begin
      busy <= (state_next == RUN);
      if (accept) begin
        a_q  <= A;
        b_q  <= B;
        op_q <= op_in;
        if ((op_in == OP_MULT) || (op_in == OP_MULTU)) begin
          cnt <= CW'(MULT_CYCLES);
        end else begin
          cnt <= CW'(DIV_CYCLES);
        end
      end else if (state == RUN) begin
        if (finish) begin
          cnt <= '0;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  // Product: sign- or zero-extend to 64 bits so one unsigned multiply serves both.
  always_comb begin
    signed_mul = (op_q == OP_MULT);
    ext_a      = {{32{signed_mul & a_q[31]}}, a_q};
    ext_b      = {{32{signed_mul & b_q[31]}}, b_q};
    product    = ext_a * ext_b;
  end

  // Quotient/remainder via magnitudes; signs are reapplied afterwards so the
  // 0x80000000 / -1 case wraps naturally to 0x80000000 with remainder 0.
  always_comb begin
    signed_div = (op_q == OP_DIV);
    is_div_q   = (op_q == OP_DIV) || (op_q == OP_DIVU);
    mag_a      = (signed_div && a_q[31]) ? (~a_q + 32'd1) : a_q;
    mag_b      = (signed_div && b_q[31]) ? (~b_q + 32'd1) : b_q;
    div_b      = (mag_b == 32'd0) ? 32'd1 : mag_b;
    uquot      = mag_a / div_b;
    urem       = mag_a % div_b;
    quot       = (signed_div && (a_q[31] ^ b_q[31])) ? (~uquot + 32'd1) : uquot;
    rem        = (signed_div && a_q[31]) ? (~urem + 32'd1) : urem;
  end

  // Select the completed result; a zero divisor leaves HI/LO untouched.
  always_comb begin
    res_hi    = product[63:32];
    res_lo    = product[31:0];
    res_write = finish;
    if (is_div_q) begin
      res_hi    = rem;
      res_lo    = quot;
      res_write = finish && (b_q != 32'd0);
    end
  end

  // HI/LO registers: result write at completion, or mthi/mtlo while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      HI <= '0;
      LO <= '0;
    end else if (res_write) begin
      HI <= res_hi;
      LO <= res_lo;
    end else if ((state == IDLE) && start) begin
      if (op_in == OP_MTHI) begin
        HI <= A;
      end else if (op_in == OP_MTLO) begin
        LO <= A;
      end
    end
  end

endmodule
